// File: rtl/pcpi_dispatch.sv
// PCPI request dispatcher: broadcasts a held core request to two coprocessors,
// locks onto the first one that responds, and returns its result or an illegal pulse.
module pcpi_dispatch #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        pcpi_illegal,
  output logic        s_valid,
  output logic [31:0] s_insn,
  output logic [31:0] s_rs1,
  output logic [31:0] s_rs2,
  input  logic        s0_wr,
  input  logic        s0_wait,
  input  logic        s0_ready,
  input  logic [31:0] s0_rd,
  input  logic        s1_wr,
  input  logic        s1_wait,
  input  logic        s1_ready,
  input  logic [31:0] s1_rd
);

  typedef enum logic [2:0] {IDLE, CLAIM, BUSY, RESP, DONE} state_t;

  state_t      state_reg;
  logic [31:0] insn_hold_reg, rs1_hold_reg, rs2_hold_reg;
  logic [31:0] rd_reg;
  logic        wr_reg, ready_reg, illegal_reg, wait_reg, s_valid_reg;
  logic        claim_reg;
  logic [7:0]  count_reg;

  logic        s0_hit, s1_hit;
  logic        new_ready, new_wr;
  logic [31:0] new_rd;
  logic        own_ready, own_wr;
  logic [31:0] own_rd;

  assign s0_hit = s0_wait | s0_ready;
  assign s1_hit = s1_wait | s1_ready;

  // Responder chosen this cycle in CLAIM (s0 wins ties).
  assign new_ready = s0_hit ? s0_ready : s1_ready;
  assign new_wr    = s0_hit ? s0_wr    : s1_wr;
  assign new_rd    = s0_hit ? s0_rd    : s1_rd;

  // Responder already locked in; the other one is ignored.
  assign own_ready = claim_reg ? s1_ready : s0_ready;
  assign own_wr    = claim_reg ? s1_wr    : s0_wr;
  assign own_rd    = claim_reg ? s1_rd    : s0_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      insn_hold_reg <= '0;
      rs1_hold_reg  <= '0;
      rs2_hold_reg  <= '0;
      rd_reg        <= '0;
      wr_reg        <= 1'b0;
      ready_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      wait_reg      <= 1'b0;
      s_valid_reg   <= 1'b0;
      claim_reg     <= 1'b0;
      count_reg     <= '0;
    end else begin
      // Result outputs are single-cycle pulses and read zero otherwise.
      ready_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      wr_reg      <= 1'b0;
      rd_reg      <= '0;
      case (state_reg)
        IDLE: begin
          if (pcpi_valid) begin
            insn_hold_reg <= pcpi_insn;
            rs1_hold_reg  <= pcpi_rs1;
            rs2_hold_reg  <= pcpi_rs2;
            count_reg     <= '0;
            s_valid_reg   <= 1'b1;
            state_reg     <= CLAIM;
          end
        end
        CLAIM: begin
          if (!pcpi_valid) begin
            s_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end else if (s0_hit || s1_hit) begin
            claim_reg <= !s0_hit;
            if (new_ready) begin
              rd_reg      <= new_rd;
              wr_reg      <= new_wr;
              ready_reg   <= 1'b1;
              s_valid_reg <= 1'b0;
              state_reg   <= RESP;
            end else begin
              wait_reg  <= 1'b1;
              state_reg <= BUSY;
            end
          end else if (count_reg + 8'd1 == 8'(TIMEOUT)) begin
            count_reg   <= count_reg + 8'd1;
            illegal_reg <= 1'b1;
            s_valid_reg <= 1'b0;
            state_reg   <= DONE;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        BUSY: begin
          if (!pcpi_valid) begin
            wait_reg    <= 1'b0;
            s_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end else if (own_ready) begin
            rd_reg      <= own_rd;
            wr_reg      <= own_wr;
            ready_reg   <= 1'b1;
            wait_reg    <= 1'b0;
            s_valid_reg <= 1'b0;
            state_reg   <= RESP;
          end
        end
        RESP: state_reg <= DONE;
        DONE: if (!pcpi_valid) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pcpi_wr      = wr_reg;
  assign pcpi_rd      = rd_reg;
  assign pcpi_wait    = wait_reg;
  assign pcpi_ready   = ready_reg;
  assign pcpi_illegal = illegal_reg;
  assign s_valid      = s_valid_reg;
  assign s_insn       = insn_hold_reg;
  assign s_rs1        = rs1_hold_reg;
  assign s_rs2        = rs2_hold_reg;

endmodule

// File: doc/pcpi_dispatch.md
PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the claim window in cycles (legal range 2..255).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcpi_valid  in  1  core request.
- pcpi_insn  in  32  core instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  result write enable, core side.
- pcpi_rd  out  32  result, core side.
- pcpi_wait  out  1  request claimed, still busy.
- pcpi_ready  out  1  one-cycle completion pulse.
- pcpi_illegal  out  1  one-cycle unclaimed-instruction pulse.
- s_valid  out  1  request broadcast to both coprocessors.
- s_insn  out  32  held instruction.
- s_rs1  out  32  held operand 1.
- s_rs2  out  32  held operand 2.
- s0_wr, s0_wait, s0_ready  in  1 each  coprocessor 0 (divider) handshake.
- s0_rd  in  32  coprocessor 0 result.
- s1_wr, s1_wait, s1_ready  in  1 each  coprocessor 1 (multiplier) handshake.
- s1_rd  in  32  coprocessor 1 result.

Function
REQ-003 FSM states SHALL be IDLE, CLAIM, BUSY, RESP, DONE.
REQ-004 IDLE: pcpi_valid=1 -> capture insn/rs1/rs2 into hold registers, go CLAIM; s_valid rises the next cycle (1-cycle issue latency).
REQ-005 s_insn/s_rs1/s_rs2 SHALL come only from hold registers and stay stable while s_valid=1.
REQ-006 s_valid SHALL be 1 exactly in CLAIM and BUSY.
REQ-007 CLAIM: first cycle sN_wait=1 or sN_ready=1 claims coprocessor N; s0 wins if both respond in the same cycle.
REQ-008 Claim by wait -> BUSY; claim by ready -> capture sN_rd/sN_wr, go RESP.
REQ-009 BUSY: claimed sN_ready=1 -> capture sN_rd/sN_wr, go RESP; unclaimed coprocessor outputs SHALL be ignored in all states.
REQ-010 pcpi_wait SHALL be 1 exactly in BUSY.
REQ-011 RESP lasts one cycle: pcpi_ready=1, pcpi_wr and pcpi_rd = captured values; then DONE.
REQ-012 pcpi_rd SHALL be 0 and pcpi_wr SHALL be 0 whenever pcpi_ready=0.
REQ-013 DONE: wait for pcpi_valid=0, then IDLE; no new capture while in DONE.
REQ-014 Timeout: an 8-bit counter clears on CLAIM entry and increments each CLAIM cycle without a claim; on reaching TIMEOUT -> one-cycle pcpi_illegal=1, s_valid drops, go DONE.
REQ-015 A claim in the same cycle the counter reaches TIMEOUT SHALL take precedence; pcpi_illegal stays 0.
REQ-016 Abort: pcpi_valid=0 in CLAIM or BUSY -> go IDLE next cycle, s_valid=0, no pcpi_ready or pcpi_illegal pulse.
REQ-017 pcpi_ready and pcpi_illegal SHALL never both be 1, and each SHALL pulse at most once per request.
REQ-018 Back-to-back requests: a new request is accepted only from IDLE, so minimum spacing is one idle cycle after pcpi_valid falls.

Reset
REQ-019 rst=1 SHALL force IDLE immediately, asynchronously.
REQ-020 During reset all outputs SHALL be 0: pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_illegal, s_valid, s_insn, s_rs1, s_rs2.
REQ-021 During reset the timeout counter and claim register SHALL be 0.
REQ-022 Reset mid-operation SHALL discard the held request with no response pulse.
REQ-023 After rst falls, the first request is accepted on the first rising edge with pcpi_valid=1.

Verification
REQ-024 DIV 100/7:
- Stimulus: s0 model asserts wait at cycle 2, ready with rd=14 at cycle 36.
- Required: pcpi_wait=1 over cycles 3..36; pcpi_ready=1, pcpi_wr=1, pcpi_rd=14 at cycle 37.
REQ-025 Same-cycle claim:
- Stimulus: s0 and s1 both assert wait at cycle 2; s1 later gives ready with rd=0xDEAD.
- Required: s1 is ignored, no pcpi_ready until s0_ready.
REQ-026 Unclaimed instruction:
- Stimulus: insn=0x0000000B, TIMEOUT=16, no responder.
- Required: pcpi_illegal pulses exactly once, 16 cycles after s_valid rises; pcpi_ready stays 0.
REQ-027 Abort:
- Stimulus: pcpi_valid drops in BUSY; s0_ready with rd=5 arrives 2 cycles later.
- Required: no pcpi_ready; IDLE within 1 cycle.
REQ-028 Reset mid-BUSY:
- Stimulus: rst pulsed asynchronously mid-cycle.
- Required: all outputs 0 before the next clock edge; the next request completes normally.
REQ-029 Immediate ready:
- Stimulus: s1 asserts ready with rd=0x12345678 at cycle 2, without wait.
- Required: pcpi_wait never 1; pcpi_ready with pcpi_rd=0x12345678 at cycle 3.
